// File: rtl/mpmc11_rd_collect.sv
// mpmc11_rd_collect: tags DRAM read-data beats with their byte address and queues them for the port.
// Optional sticky protocol-error flag is built only when MPMC11_RDC_ERR_EN is defined.

module mpmc11_rd_collect #(
  parameter int WID        = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    addr_base,
  input  logic [5:0]     burst_len,
  input  logic           rd_valid,
  input  logic [WID-1:0] rd_data,
  input  logic           o_ready,
  output logic           o_valid,
  output logic [31:0]    o_addr,
  output logic [WID-1:0] o_data,
  output logic [5:0]     beat_cnt,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic           err
);

  localparam int INC_AMT = WID / 8;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [31:0]      ADDR_INC   = 32'(INC_AMT);
  localparam logic [31:0]      ALIGN_MASK = ~(ADDR_INC - 32'd1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0] nxtAddr_q, nxtAddr_d;
  logic [5:0]  burstLen_q, burstLen_d;
  logic [5:0]  beatCnt_q, beatCnt_d;
  logic        overflow_q, overflow_d;

  logic [31:0]      addrMem [FIFO_DEPTH];
  logic [WID-1:0]   dataMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      lastAddr_q, lastAddr_d;
  logic [WID-1:0]   lastData_q, lastData_d;

  logic acceptStart;
  logic beatIn;
  logic lastBeat;
  logic fifoEmpty;
  logic fifoFull;
  logic push;
  logic pop;
  logic drop;

  assign acceptStart = (state_q == S_IDLE) && start;
  assign beatIn      = (state_q == S_COLLECT) && rd_valid;
  assign lastBeat    = beatIn && (beatCnt_q == burstLen_q);
  assign fifoEmpty   = (count_q == '0);
  assign fifoFull    = (count_q == FULL_CNT);
  assign pop         = !fifoEmpty && o_ready;
  // A full queue still accepts a beat when the head leaves in the same cycle.
  assign push        = beatIn && (!fifoFull || pop);
  assign drop        = beatIn && fifoFull && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (lastBeat) state_d = S_DRAIN;
      S_DRAIN:   if (fifoEmpty) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    unique case (state_q)
      S_IDLE:  busy = 1'b0;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The final beat leaves beat_cnt at burst_len, so a 64-beat burst never wraps the 6-bit count.
  always_comb begin
    nxtAddr_d  = nxtAddr_q;
    burstLen_d = burstLen_q;
    beatCnt_d  = beatCnt_q;
    overflow_d = overflow_q;
    if (acceptStart) begin
      nxtAddr_d  = addr_base & ALIGN_MASK;
      burstLen_d = burst_len;
      beatCnt_d  = 6'd0;
      overflow_d = 1'b0;
    end else if (beatIn) begin
      nxtAddr_d = nxtAddr_q + ADDR_INC;
      if (!lastBeat) beatCnt_d = beatCnt_q + 6'd1;
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxtAddr_q  <= '0;
      burstLen_q <= '0;
      beatCnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      nxtAddr_q  <= nxtAddr_d;
      burstLen_q <= burstLen_d;
      beatCnt_q  <= beatCnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    wrPtr_d    = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d    = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    lastAddr_d = pop ? addrMem[rdPtr_q] : lastAddr_q;
    lastData_d = pop ? dataMem[rdPtr_q] : lastData_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      lastAddr_q <= '0;
      lastData_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      lastAddr_q <= lastAddr_d;
      lastData_q <= lastData_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr_q] <= nxtAddr_q;
      dataMem[wrPtr_q] <= rd_data;
    end
  end

  // Once empty, the port keeps seeing the last beat it consumed.
  assign o_valid  = !fifoEmpty;
  assign o_addr   = fifoEmpty ? lastAddr_q : addrMem[rdPtr_q];
  assign o_data   = fifoEmpty ? lastData_q : dataMem[rdPtr_q];
  assign beat_cnt = beatCnt_q;
  assign overflow = overflow_q;

`ifdef MPMC11_RDC_ERR_EN
  logic errEvent;
  logic err_q, err_d;

  assign errEvent = (rd_valid && (state_q != S_COLLECT)) || (start && (state_q != S_IDLE));

  always_comb begin
    err_d = err_q;
    if (acceptStart) err_d = 1'b0;
    if (errEvent) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
